led_blink_sched: RTL and testbench
==================================

LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 Parameter: CLK_DIV, 50000, clock cycles per tick (>=2).
REQ-002 Parameter: CNT_W, 8, width of on/off/repeat fields.
REQ-003 Port: clk  in  1  system clock, rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: cmd_valid  in  1  command offered.
REQ-006 Port: cmd_ready  out  1  command can be accepted.
REQ-007 Port: cmd_on_ticks  in  CNT_W  LED-on phase length, in ticks.
REQ-008 Port: cmd_off_ticks  in  CNT_W  LED-off phase length, in ticks.
REQ-009 Port: cmd_repeat  in  CNT_W  on/off cycles to run; 0 = forever.
REQ-010 Port: abort  in  1  cancel the active sequence.
REQ-011 Port: led  out  1  LED drive, registered.
REQ-012 Port: busy  out  1  sequence active (state != IDLE).
REQ-013 Port: done  out  1  one-cycle pulse on normal completion.

Function
REQ-014 FSM states: IDLE, ON, OFF.
REQ-015 Handshake: accept on a clk edge with cmd_valid && cmd_ready; all cmd_* fields are latched at accept.
REQ-016 cmd_ready = (state==IDLE) && !abort.
REQ-017 Prescaler: counts 0..CLK_DIV-1 and emits a tick at CLK_DIV-1; cleared at accept so phase timing is exact.
REQ-018 Accept with on_ticks!=0: ON in the next cycle; led=1 for exactly on_ticks*CLK_DIV cycles.
REQ-019 ON end: go to OFF (led=0) for off_ticks*CLK_DIV cycles.
REQ-020 off_ticks==0: OFF is skipped and led stays 1 across cycle boundaries.
REQ-021 A cycle completes at the end of OFF, or at the end of ON when off_ticks==0. The completed-cycle counter (CNT_W bits) then increments.
REQ-022 If repeat!=0 and the completed count equals repeat: go to IDLE, led=0, and pulse done in the first IDLE cycle.
REQ-023 If repeat==0: run until abort; the cycle counter wraps silently.
REQ-024 Accept with on_ticks==0: the FSM stays in IDLE, led stays 0, and done pulses in the next cycle.
REQ-025 abort in any non-IDLE state: IDLE next cycle, led=0, no done pulse. abort wins over a simultaneous completion.
REQ-026 abort in IDLE: no effect, and no accept that cycle.

Reset
REQ-027 While rst_n is low, all outputs are forced immediately: led=0, busy=0, done=0, cmd_ready=1 (after release). FSM=IDLE; prescaler and counters = 0.
REQ-028 Reset mid-sequence discards the sequence and any queued command; no done pulse.

Configuration
REQ-029 Macro LED_BLINK_SCHED_QUEUE_EN, defined: a one-entry command queue is added.
- cmd_ready = !queue_full && !abort.
- A command accepted while busy is held in the queue.
- The queued command starts in the cycle after the active command's done pulse, with no IDLE gap (busy stays 1).
- abort clears both the active and the queued command.
REQ-030 Macro LED_BLINK_SCHED_QUEUE_EN, undefined: no queue; behaviour is exactly as in REQ-016.

Structure
REQ-031 Shared package led_blink_pkg holds: the FSM state enum (IDLE/ON/OFF), the command struct type {on, off, repeat}, and the default CLK_DIV constant.
REQ-032 Sub-module led_tick_gen (prescaler with clear input, tick output) is instantiated once.

Verification
REQ-033 Use CLK_DIV=4 in the bench for the scenarios below.
REQ-034 Reset: assert rst_n=0 mid-ON -> led=0 with no clock edge; after release, busy=0 and cmd_ready=1.
REQ-035 Finite sequence: on=2, off=3, repeat=2 -> led high 8 cycles, low 12, high 8, low 12; done pulses once at cycle 41 after accept; busy=0 from then.
REQ-036 Continuous with abort: on=1, off=1, repeat=0 -> led toggles every 4 cycles; abort at cycle 25 -> led=0 and busy=0 next cycle; done never pulses.
REQ-037 Zero-length command:
- on=0, repeat=3 -> led never high; done pulses 1 cycle after accept.
- off=0, on=1, repeat=3 -> led high a continuous 12 cycles, then done.
REQ-038 Queue (macro on): issue B={1,1,1} while A={1,1,1} is in ON -> B accepted; led rises the cycle after A's done; busy continuous.
REQ-039 No queue (macro off): the same stimulus holds cmd_ready=0 until A's done; B is accepted only after that.

Source files
------------

// File: rtl/led_blink_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_blink_pkg : shared types and defaults for the LED blink scheduler    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package led_blink_pkg;

  localparam int unsigned CLK_DIV_DEF = 50000;
  localparam int unsigned CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] on_ticks;
    logic [CNT_W_DEF-1:0] off_ticks;
    logic [CNT_W_DEF-1:0] rpt;
  } cmd_t;

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_tick_gen : prescaler, one-cycle tick every CLK_DIV clocks, clearable |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module led_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_blink_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_blink_sched : on/off LED blink sequencer with repeat count and abort |
// | Optional one-entry command queue: define LED_BLINK_SCHED_QUEUE_EN        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module led_blink_sched
  import led_blink_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_on_ticks,
  input  logic [CNT_W-1:0] cmd_off_ticks,
  input  logic [CNT_W-1:0] cmd_repeat,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic             r_led;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_on;
  logic [CNT_W-1:0] r_off;
  logic [CNT_W-1:0] r_rep;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_cycles;

  logic             w_tick;
  logic             w_start;
  logic             w_pending;
  logic [CNT_W-1:0] w_s_on;
  logic [CNT_W-1:0] w_s_off;
  logic [CNT_W-1:0] w_s_rep;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_cyc_next;
  logic             w_phase_end;
  logic             w_cyc_done;
  logic             w_last;

`ifdef LED_BLINK_SCHED_QUEUE_EN
  logic             r_q_valid;
  logic [CNT_W-1:0] r_q_on;
  logic [CNT_W-1:0] r_q_off;
  logic [CNT_W-1:0] r_q_rep;
  logic             w_push;

  assign cmd_ready = !r_q_valid && !abort;
  assign w_push    = cmd_valid && cmd_ready && (r_state != ST_IDLE);
  assign w_start   = (r_state == ST_IDLE) && !abort && (r_q_valid || cmd_valid);
  assign w_s_on    = r_q_valid ? r_q_on  : cmd_on_ticks;
  assign w_s_off   = r_q_valid ? r_q_off : cmd_off_ticks;
  assign w_s_rep   = r_q_valid ? r_q_rep : cmd_repeat;
  // A pending command keeps busy high through the done cycle.
  assign w_pending = r_q_valid || w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid <= 1'b0;
      r_q_on    <= '0;
      r_q_off   <= '0;
      r_q_rep   <= '0;
    end else if (abort) begin
      r_q_valid <= 1'b0;
    end else if (w_start && r_q_valid) begin
      r_q_valid <= 1'b0;
    end else if (w_push) begin
      r_q_valid <= 1'b1;
      r_q_on    <= cmd_on_ticks;
      r_q_off   <= cmd_off_ticks;
      r_q_rep   <= cmd_repeat;
    end
  end
`else
  assign cmd_ready = (r_state == ST_IDLE) && !abort;
  assign w_start   = cmd_valid && cmd_ready;
  assign w_s_on    = cmd_on_ticks;
  assign w_s_off   = cmd_off_ticks;
  assign w_s_rep   = cmd_repeat;
  assign w_pending = 1'b0;
`endif

  led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start),
    .o_tick  (w_tick)
  );

  assign w_len       = (r_state == ST_ON) ? r_on : r_off;
  assign w_phase_end = w_tick && (r_phase == w_len - 1'b1);
  assign w_cyc_done  = (r_state == ST_OFF) || (r_off == '0);
  assign w_cyc_next  = r_cycles + 1'b1;
  assign w_last      = (r_rep != '0) && (w_cyc_next == r_rep);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_led    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_on     <= '0;
      r_off    <= '0;
      r_rep    <= '0;
      r_phase  <= '0;
      r_cycles <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_on     <= w_s_on;
            r_off    <= w_s_off;
            r_rep    <= w_s_rep;
            r_phase  <= '0;
            r_cycles <= '0;
            if (w_s_on != '0) begin
              r_state <= ST_ON;
              r_led   <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        default: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_phase_end) begin
            r_phase <= '0;
            if (!w_cyc_done) begin
              r_state <= ST_OFF;
              r_led   <= 1'b0;
            end else begin
              r_cycles <= w_cyc_next;
              if (w_last) begin
                r_state <= ST_IDLE;
                r_led   <= 1'b0;
                r_done  <= 1'b1;
                r_busy  <= w_pending;
              end else begin
                r_state <= ST_ON;
                r_led   <= 1'b1;
              end
            end
          end else if (w_tick) begin
            r_phase <= r_phase + 1'b1;
          end
        end
      endcase
    end
  end

  assign led  = r_led;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_led_blink_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_blink_sched : self-checking bench, CLK_DIV=4, directed + random   |
// | Queue expectations follow LED_BLINK_SCHED_QUEUE_EN                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_led_blink_sched;
  import led_blink_pkg::*;

  localparam int D = 4;
  localparam int W = 8;

  typedef struct {
    cmd_t c;
    int   abort_at;
    int   exp_done;
    int   exp_high;
    int   exp_busy;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cmd_on_ticks = '0;
  logic [W-1:0] cmd_off_ticks = '0;
  logic [W-1:0] cmd_repeat = '0;
  logic         cmd_ready;
  logic         led;
  logic         busy;
  logic         done;

  int n_chk  = 0;
  int n_pass = 0;

  led_blink_sched #(.CLK_DIV(D), .CNT_W(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_on_ticks  (cmd_on_ticks),
    .cmd_off_ticks (cmd_off_ticks),
    .cmd_repeat    (cmd_repeat),
    .abort         (abort),
    .led           (led),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got hang, expected finish)");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs derived from the sequence timeline: cycle k after accept.
  task automatic run_cmd(input cmd_t c, input int abort_at,
                         output int done_cyc, output int high, output int busy_n);
    int p, end_k, last, on_c;
    bit aborted, active, eled, edone;
    done_cyc = 0; high = 0; busy_n = 0;
    cmd_valid = 1'b1; abort = 1'b0;
    cmd_on_ticks = c.on_ticks; cmd_off_ticks = c.off_ticks; cmd_repeat = c.rpt;
    #1;
    check("ready_idle", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    on_c  = int'(c.on_ticks) * D;
    p     = (int'(c.on_ticks) + int'(c.off_ticks)) * D;
    end_k = (c.on_ticks == 0) ? 0 : (c.rpt == 0) ? (1 << 30) : int'(c.rpt) * p;
    last  = ((abort_at > 0 && abort_at < end_k) ? abort_at : end_k) + 2;
    for (int k = 1; k <= last; k++) begin
      aborted = (abort_at > 0) && (abort_at <= end_k) && (k > abort_at);
      active  = (c.on_ticks != 0) && (k <= end_k) && !aborted;
      eled    = active ? (((k - 1) % p) < on_c) : 1'b0;
      edone   = !aborted && (k == end_k + 1);
      check($sformatf("cyc%0d{led,busy,done}", k), int'({led, busy, done}),
            int'({eled, active, edone}));
      if (led) high++;
      if (busy) busy_n++;
      if (done && done_cyc == 0) done_cyc = k;
      abort = (k == abort_at);
      step();
    end
    abort = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int   dc, hi, bs, acc;
    logic l_led[21], l_busy[21], l_done[21];
    int   n_done, n_high;
    cmd_t rc;
    int   ab, p, end_k;

    vecs[0] = '{'{8'd2, 8'd3, 8'd2}, 0,  41, 16, 40};
    vecs[1] = '{'{8'd1, 8'd1, 8'd0}, 25, 0,  13, 25};
    vecs[2] = '{'{8'd0, 8'd5, 8'd3}, 0,  1,  0,  0};
    vecs[3] = '{'{8'd1, 8'd0, 8'd3}, 0,  13, 12, 12};
    vecs[4] = '{'{8'd3, 8'd2, 8'd1}, 20, 0,  12, 20};
    vecs[5] = '{'{8'd3, 8'd2, 8'd1}, 0,  21, 12, 20};

    // Outputs while in reset
    #12;
    check("rst_outputs{led,busy,done}", int'({led, busy, done}), 0);
    check("rst_ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i].c, vecs[i].abort_at, dc, hi, bs);
      check($sformatf("vec%0d_done_cycle", i), dc, vecs[i].exp_done);
      check($sformatf("vec%0d_led_high", i), hi, vecs[i].exp_high);
      check($sformatf("vec%0d_busy_cycles", i), bs, vecs[i].exp_busy);
      step();
    end

    // Asynchronous reset in the middle of ON
    cmd_valid = 1'b1; cmd_on_ticks = 8'd2; cmd_off_ticks = 8'd3; cmd_repeat = 8'd2;
    step();
    cmd_valid = 1'b0;
    step(); step();
    check("prerst_led", int'(led), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst{led,busy,done}", int'({led, busy, done}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("postrst_busy", int'(busy), 0);
    check("postrst_ready", int'(cmd_ready), 1);
    n_high = 0; n_done = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (led) n_high++;
      if (done || busy) n_done++;
    end
    check("postrst_led_high", n_high, 0);
    check("postrst_done_busy", n_done, 0);

    // Second command offered while the first is in ON
    cmd_valid = 1'b1; cmd_on_ticks = 8'd1; cmd_off_ticks = 8'd1; cmd_repeat = 8'd1;
    step();
    acc = -1;
    cmd_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      l_led[k] = led; l_busy[k] = busy; l_done[k] = done;
      if (k == 2) cmd_valid = 1'b1;
      #1;
      if (cmd_valid && cmd_ready && acc < 0) acc = k;
      step();
      if (acc >= 0) cmd_valid = 1'b0;
    end
`ifdef LED_BLINK_SCHED_QUEUE_EN
    check("q_accept_cycle", acc, 2);
    check("q_busy_at_done", int'(l_busy[9]), 1);
`else
    check("q_accept_cycle", acc, 9);
    check("q_busy_at_done", int'(l_busy[9]), 0);
`endif
    check("q_a_done", int'(l_done[9]), 1);
    check("q_led_at_done", int'(l_led[9]), 0);
    check("q_b_led_rise", int'(l_led[10]), 1);
    check("q_b_busy", int'(l_busy[10]), 1);
    check("q_b_off", int'(l_led[14]), 0);
    check("q_b_done", int'(l_done[18]), 1);
    check("q_b_idle", int'(l_busy[18]), 0);
    n_done = 0;
    for (int k = 1; k <= 20; k++) if (l_done[k]) n_done++;
    check("q_done_count", n_done, 2);

    // Random commands against the timeline model, with idle-time aborts
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) begin
          cmd_valid = 1'b1; abort = 1'b1;
          cmd_on_ticks = 8'd1; cmd_off_ticks = 8'd1; cmd_repeat = 8'd1;
          #1;
          check("idle_abort_ready", int'(cmd_ready), 0);
          step();
          cmd_valid = 1'b0; abort = 1'b0;
          check("idle_abort_noaccept{led,busy,done}", int'({led, busy, done}), 0);
        end else begin
          step();
          check("idle{led,busy,done}", int'({led, busy, done}), 0);
        end
      end
      rc.on_ticks  = W'($urandom_range(0, 3));
      rc.off_ticks = W'($urandom_range(0, 3));
      rc.rpt       = W'($urandom_range(0, 3));
      p     = (int'(rc.on_ticks) + int'(rc.off_ticks)) * D;
      end_k = int'(rc.rpt) * p;
      if (rc.on_ticks != 0 && rc.rpt == 0) ab = $urandom_range(1, 40);
      else if ($urandom_range(0, 2) == 0) ab = $urandom_range(1, end_k + 1);
      else ab = 0;
      run_cmd(rc, ab, dc, hi, bs);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
